// File: rtl/vga_pixel_streamer_if.sv
// Pixel stream handshake between an upstream source and vga_pixel_streamer.
//   s_pixel : RGB444 pixel
//   s_sof   : first pixel (address 0) of a frame
//   s_valid : source has a pixel
//   s_ready : streamer can accept a pixel
interface vga_pixel_streamer_if;
  logic [11:0] s_pixel;
  logic        s_sof;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_pixel, output s_sof, output s_valid, input s_ready);
  modport slave  (input s_pixel, input s_sof, input s_valid, output s_ready);
endinterface

// File: rtl/vga_pixel_streamer.sv
// Feeds the VGA output stage: buffers an RGB444 stream in a FIFO, generates the
// pixel timing at the pixel-tick rate, locks to the stream's start-of-frame
// marker and pops one pixel per visible slot.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   s            : pixel stream (slave side; s_ready = FIFO not full)
//   address_out  : linear address of the pixel on data_out
//   data_out     : pixel colour (BLANK_COLOR when no real pixel)
//   pix_valid    : data_out carries a FIFO pixel
//   frame_start  : 1-clk pulse with the h=0,v=0 tick output
//   underflow    : 1-clk pulse, visible slot with empty FIFO while streaming
module vga_pixel_streamer #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_VIS_START = 144,
  parameter int unsigned V_VIS_START = 35,
  parameter int unsigned H_VIS       = 640,
  parameter int unsigned V_VIS       = 480,
  parameter logic [11:0] BLANK_COLOR = 12'h000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vga_pixel_streamer_if.slave    s,
  output logic [18:0]            address_out,
  output logic [11:0]            data_out,
  output logic                   pix_valid,
  output logic                   frame_start,
  output logic                   underflow
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);
  localparam int unsigned H_W    = $clog2(H_TOTAL + 1);
  localparam int unsigned V_W    = $clog2(V_TOTAL + 1);
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic        sof;
    logic [11:0] pixel;
  } entry_t;

  typedef enum logic {ALIGN = 1'b0, STREAM = 1'b1} state_t;

  logic [DIV_W-1:0]  div;
  logic [H_W-1:0]    h;
  logic [V_W-1:0]    v;
  logic [ADDR_W-1:0] addr;
  logic              tick_c, vis_c, fs_c;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              ready_q;
  logic              push_c, pop_c, empty_c;
  entry_t            head;

  state_t            state, state_nxt;
  logic [11:0]       out_pix_c;
  logic              out_valid_c, uflow_c;

  assign tick_c  = (div == DIV_W'(CLK_DIV - 1));
  assign vis_c   = tick_c
                && (h >= H_W'(H_VIS_START)) && (h < H_W'(H_VIS_START + H_VIS))
                && (v >= V_W'(V_VIS_START)) && (v < V_W'(V_VIS_START + V_VIS));
  assign fs_c    = tick_c && (h == '0) && (v == '0);

  assign push_c  = s.s_valid && ready_q;
  assign empty_c = (count == '0);
  assign head    = mem[rd_ptr];
  assign s.s_ready = ready_q;

  // Tick divider, raster counters and linear address counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div  <= '0;
      h    <= '0;
      v    <= '0;
      addr <= '0;
    end else begin
      div <= tick_c ? '0 : div + DIV_W'(1);
      if (tick_c) begin
        if (h == H_W'(H_TOTAL - 1)) begin
          h <= '0;
          v <= (v == V_W'(V_TOTAL - 1)) ? '0 : v + V_W'(1);
        end else begin
          h <= h + H_W'(1);
        end
        // Counter may sit one past the last pixel during blanking; address_out
        // only samples it on visible slots.
        if (fs_c)       addr <= '0;
        else if (vis_c) addr <= addr + ADDR_W'(1);
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= '{sof: s.s_sof, pixel: s.s_pixel};
  end

  always_comb begin
    count_nxt = count;
    if (push_c && !pop_c)      count_nxt = count + CNT_W'(1);
    else if (!push_c && pop_c) count_nxt = count - CNT_W'(1);
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_nxt;
      ready_q <= (count_nxt != CNT_W'(DEPTH));
    end
  end

  // Lock state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ALIGN;
    else        state <= state_nxt;
  end

  // Lock/stream decisions: pop, next state and the value for the next output
  always_comb begin
    state_nxt   = state;
    pop_c       = 1'b0;
    out_pix_c   = BLANK_COLOR;
    out_valid_c = 1'b0;
    uflow_c     = 1'b0;
    case (state)
      ALIGN: begin
        if (!empty_c) begin
          if (!head.sof) begin
            pop_c = 1'b1;
          end else if (vis_c && (addr == '0)) begin
            pop_c       = 1'b1;
            out_pix_c   = head.pixel;
            out_valid_c = 1'b1;
            state_nxt   = STREAM;
          end
        end
      end
      STREAM: begin
        if (vis_c) begin
          if (empty_c) begin
            uflow_c   = 1'b1;
            state_nxt = ALIGN;
          end else if (head.sof != (addr == '0)) begin
            // Marker and raster disagree: keep the entry for ALIGN to sort out
            state_nxt = ALIGN;
          end else begin
            pop_c       = 1'b1;
            out_pix_c   = head.pixel;
            out_valid_c = 1'b1;
          end
        end
      end
      default: state_nxt = ALIGN;
    endcase
  end

  // Registered video outputs, updated on ticks and held between them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      address_out <= '0;
      data_out    <= BLANK_COLOR;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      frame_start <= fs_c;
      underflow   <= uflow_c;
      if (tick_c) begin
        data_out  <= out_pix_c;
        pix_valid <= out_valid_c;
        if (vis_c) address_out <= addr;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_streamer.sv
// Scoreboard bench for vga_pixel_streamer on a reduced 20x10 raster
// (8x5 visible at h=4, v=2), so a frame is 800 clks and holds 40 pixels.
module tb_vga_pixel_streamer;
  localparam int unsigned CLK_DIV     = 4;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned H_TOTAL     = 20;
  localparam int unsigned V_TOTAL     = 10;
  localparam int unsigned H_VIS_START = 4;
  localparam int unsigned V_VIS_START = 2;
  localparam int unsigned H_VIS       = 8;
  localparam int unsigned V_VIS       = 5;
  localparam logic [11:0] BLANK       = 12'h5A5;
  localparam int          FRAME_CLKS  = 800;  // 4 * 20 * 10
  localparam int          SOF_LAT     = 176;  // 4 * (2*20 + 4)
  localparam int          LAST_PIX    = 39;

  typedef struct packed {
    logic [18:0] a;
    logic [11:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [18:0] address_out;
  logic [11:0] data_out;
  logic        pix_valid, frame_start, underflow;

  vga_pixel_streamer_if sif();

  vga_pixel_streamer #(
    .CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
    .H_VIS_START(H_VIS_START), .V_VIS_START(V_VIS_START),
    .H_VIS(H_VIS), .V_VIS(V_VIS), .BLANK_COLOR(BLANK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s(sif),
    .address_out(address_out), .data_out(data_out), .pix_valid(pix_valid),
    .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          uf_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          fs_cyc = 0;
  logic        prev_v = 1'b0;
  logic [18:0] prev_a = '0;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each newly presented pixel and each underflow pulse is popped
  // from its queue and compared.
  always @(negedge clk) begin
    exp_t e;
    if (frame_start) fs_cyc = cyc;
    if (pix_valid && (!prev_v || address_out != prev_a)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", int'(address_out), -1);
      end else begin
        e = exp_q.pop_front();
        check("pix_addr", int'(address_out), int'(e.a));
        check("pix_data", int'(data_out), int'(e.d));
        if (e.a == '0) check("sof_latency", cyc - fs_cyc, SOF_LAT);
      end
    end
    if (underflow) begin
      if (uf_q.size() == 0) check("unexpected_underflow", int'(address_out), -1);
      else                  check("underflow_addr", int'(address_out), uf_q.pop_front());
    end
    prev_v = pix_valid;
    prev_a = address_out;
  end

  // Present one pixel and hold it until accepted; returns on the negedge after the push.
  task automatic send(input logic [11:0] p, input logic sof);
    int guard = 0;
    sif.s_pixel = p;
    sif.s_sof   = sof;
    sif.s_valid = 1'b1;
    while (!sif.s_ready && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (!sif.s_ready) begin
      $display("FAIL send_timeout: got s_ready=0 expected 1");
      $fatal(1, "source stalled");
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] tag, input int first, input int last);
    exp_t e;
    for (int i = first; i <= last; i++) begin
      e.a = 19'(i);
      e.d = {tag, 8'(i)};
      exp_q.push_back(e);
      send(e.d, i == 0);
    end
    sif.s_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_s_ready"}, int'(sif.s_ready), 1);
    check({tag, "_pix_valid"}, int'(pix_valid), 0);
    check({tag, "_data_out"}, int'(data_out), int'(BLANK));
    check({tag, "_address_out"}, int'(address_out), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_underflow"}, int'(underflow), 0);
  endtask

  // After reset release at a negedge, frame_start shows on the 4th clk only.
  task automatic check_fs_start(input string tag);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check({tag, "_fs_clk"}, int'(frame_start), (k == 4) ? 1 : 0);
    end
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 5000);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_pixel = '0;
    sif.s_sof   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    check_fs_start("por");
    wait_fs(n);
    check("fs_period", n, FRAME_CLKS);
    check("idle_ready", int'(sif.s_ready), 1);

    // Lock on a held sof head; FIFO fills while waiting for address 0
    send_frame(4'h1, 0, 15);
    check("full_ready_low", int'(sif.s_ready), 0);
    send_frame(4'h1, 16, LAST_PIX);
    send_frame(4'h2, 0, LAST_PIX);

    // Source stalls after 20 pixels: one underflow at address 20, relock next frame
    send_frame(4'h3, 0, 19);
    uf_q.push_back(20);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!underflow && n < 3000);
    check("underflow_seen", int'(underflow), 1);
    send_frame(4'h4, 0, LAST_PIX);

    // Stray pixels without sof are dropped, next sof frame streams intact
    for (int i = 0; i < 5; i++) send(12'hF00 | 12'(i), 1'b0);
    sif.s_valid = 1'b0;
    send_frame(4'h5, 0, LAST_PIX);

    // Mid-frame reset at address 20 with a stale sof entry queued behind
    send_frame(4'h6, 0, 25);
    send(12'hE00, 1'b1);
    sif.s_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pix_valid && address_out == 19'd20 && data_out[11:8] == 4'h6) && n < 5000);
    check("reset_point", int'(address_out), 20);
    @(negedge clk);
    exp_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid");
    rst_n = 1'b1;
    check_fs_start("mid");
    send_frame(4'h7, 0, LAST_PIX);

    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    check("drained_pixels", exp_q.size(), 0);
    check("drained_underflows", uf_q.size(), 0);
    check("final_ready", int'(sif.s_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
